// File: rtl/byte_op_pkg.sv
// Shared constants, state encoding and instruction decode for the byte-op sequencer.
package byte_op_pkg;

  localparam logic [2:0]  OP_MOVL  = 3'd0;
  localparam logic [2:0]  OP_MOVLZ = 3'd1;
  localparam logic [2:0]  OP_MOVLS = 3'd2;
  localparam logic [2:0]  OP_MOVH  = 3'd3;
  localparam logic [2:0]  OP_SWPB  = 3'd4;

  localparam logic [2:0]  MOVE_PREFIX = 3'b011;
  localparam logic [12:0] SWPB_PREFIX = 13'h09B0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WAIT = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [2:0] op;
    logic [7:0] byte_val;
    logic [2:0] dst;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] w);
    dec_t d;
    d.legal    = 1'b0;
    d.op       = OP_MOVL;
    d.byte_val = 8'h00;
    d.dst      = w[2:0];
    if (w[15:13] == MOVE_PREFIX) begin
      d.legal    = 1'b1;
      d.op       = {1'b0, w[12:11]};
      d.byte_val = w[10:3];
    end else if (w[15:3] == SWPB_PREFIX) begin
      d.legal = 1'b1;
      d.op    = OP_SWPB;
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_bank8x16.sv
// 8x16 register bank: one write port, one latched read port, one combinational debug port.
module reg_bank8x16 #(
  parameter int          NREGS   = 8,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic        rd_en,
  input  logic [2:0]  raddr,
  output logic [15:0] rdata,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  logic [15:0] regs_q [NREGS];
  logic [15:0] regs_d [NREGS];
  logic [15:0] rdata_q, rdata_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = regs_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RST_VAL;
      rdata_q <= 16'h0000;
    end else begin
      regs_q  <= regs_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata    = rdata_q;
  // Old contents are visible during the write cycle; new ones from the next.
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/byte_op_sequencer.sv
// Issue/writeback sequencer that drives the byte-manipulation unit and writes results back.
// state | meaning
// IDLE  | ready for an instruction word
// READ  | latch destination register into bm_dst_in
// EXEC  | bm_e pulse
// WAIT  | unit result settles
// WB    | write bm_dst_out to destination, done pulse
module byte_op_sequencer
  import byte_op_pkg::*;
#(
  parameter int          NREGS   = 8,
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  output logic [2:0]  bm_op,
  output logic [7:0]  bm_byte,
  output logic [15:0] bm_dst_in,
  output logic        bm_e,
  input  logic [15:0] bm_dst_out,
  output logic        done,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] dst_q, dst_d;
  logic       bm_e_q, bm_e_d;
  logic       illegal_q, illegal_d;
  logic       rd_en, wb_en;
  dec_t       dec;

  assign inst_ready = (state_q == ST_IDLE) && !illegal_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    byte_d    = byte_q;
    dst_d     = dst_q;
    bm_e_d    = 1'b0;
    illegal_d = 1'b0;
    rd_en     = 1'b0;
    wb_en     = 1'b0;
    dec       = decode(inst);
    case (state_q)
      ST_IDLE: begin
        if (inst_valid && inst_ready) begin
          if (dec.legal) begin
            op_d    = dec.op;
            byte_d  = dec.byte_val;
            dst_d   = dec.dst;
            state_d = ST_READ;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        bm_e_d  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_WB;
      ST_WB: begin
        wb_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bm_e is a flop so reset drops it asynchronously mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MOVL;
      byte_q    <= 8'h00;
      dst_q     <= 3'd0;
      bm_e_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      byte_q    <= byte_d;
      dst_q     <= dst_d;
      bm_e_q    <= bm_e_d;
      illegal_q <= illegal_d;
    end
  end

  reg_bank8x16 #(
    .NREGS   (NREGS),
    .RST_VAL (RST_VAL)
  ) u_regs (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_en),
    .waddr    (dst_q),
    .wdata    (bm_dst_out),
    .rd_en    (rd_en),
    .raddr    (dst_q),
    .rdata    (bm_dst_in),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign bm_op   = op_q;
  assign bm_byte = byte_q;
  assign bm_e    = bm_e_q;
  assign done    = wb_en;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_byte_op_sequencer.sv
// Scoreboard bench for byte_op_sequencer with a behavioural byte-manipulation unit and register model.
module tb_byte_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  bm_op;
  logic [7:0]  bm_byte;
  logic [15:0] bm_dst_in;
  logic        bm_e;
  logic [15:0] bm_dst_out;
  logic        done;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  byte_op_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .bm_op      (bm_op),
    .bm_byte    (bm_byte),
    .bm_dst_in  (bm_dst_in),
    .bm_e       (bm_e),
    .bm_dst_out (bm_dst_out),
    .done       (done),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  typedef struct {
    bit        ill;
    bit [2:0]  op;
    bit [7:0]  b;
    bit [15:0] din;
  } exp_t;

  exp_t      exp_q[$];
  bit [15:0] model [8];
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        last_bme = 0;
  int        done_cnt = 0;
  int        exp_done_cnt = 0;

  function automatic bit [15:0] unit_result(input bit [2:0] op, input bit [7:0] b, input bit [15:0] d);
    case (op)
      3'd0:    return {d[15:8], b};
      3'd1:    return {8'h00, b};
      3'd2:    return {{8{b[7]}}, b};
      3'd3:    return {b, d[7:0]};
      3'd4:    return {d[7:0], d[15:8]};
      default: return d;
    endcase
  endfunction

  assign bm_dst_out = unit_result(bm_op, bm_byte, bm_dst_in);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops one expectation per bm_e or illegal pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bm_e === 1'b1) begin
        if (exp_q.size() == 0) chk("bme_unexpected", 16'd1, 16'd0);
        else begin
          e = exp_q.pop_front();
          chk("bme_on_legal", 16'(e.ill), 16'd0);
          chk("bm_op", 16'(bm_op), 16'(e.op));
          chk("bm_byte", 16'(bm_byte), 16'(e.b));
          chk("bm_dst_in", bm_dst_in, e.din);
        end
        last_bme = cyc;
      end
      if (illegal === 1'b1) begin
        if (exp_q.size() == 0) chk("illegal_unexpected", 16'd1, 16'd0);
        else begin
          e = exp_q.pop_front();
          chk("illegal_on_illegal", 16'(e.ill), 16'd1);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_latency", 16'(cyc - last_bme), 16'd2);
      end
    end
  end

  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("reg%0d", i), dbg_data, model[i]);
    end
  endtask

  task automatic peek(input string name, input bit [2:0] r, input bit [15:0] v);
    dbg_addr = r;
    #1;
    chk(name, dbg_data, v);
  endtask

  task automatic issue(input bit [15:0] w, input bit junk);
    bit       legal;
    bit [2:0] op;
    bit [2:0] dst;
    bit [7:0] b;
    exp_t     e;
    int       n;
    legal = 1'b0;
    op    = 3'd0;
    b     = 8'h00;
    dst   = w[2:0];
    if (w[15:13] == 3'b011) begin
      legal = 1'b1;
      op    = {1'b0, w[12:11]};
      b     = w[10:3];
    end else if (w[15:3] == 13'h09B0) begin
      legal = 1'b1;
      op    = 3'd4;
    end
    @(negedge clk);
    inst       = w;
    inst_valid = 1'b1;
    n = 0;
    while (!inst_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inst_ready) begin
      chk("accept_timeout", 16'd0, 16'd1);
      inst_valid = 1'b0;
      return;
    end
    e.ill = !legal;
    e.op  = op;
    e.b   = b;
    e.din = model[dst];
    if (legal) begin
      model[dst] = unit_result(op, b, model[dst]);
      exp_done_cnt++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (junk && legal) inst = 16'($urandom);
    else inst_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!inst_ready && n < 20) begin
      n++;
      if (n == 3) inst_valid = 1'b0;
      @(negedge clk);
    end
    inst_valid = 1'b0;
    chk("ready_gap", 16'(n), legal ? 16'd4 : 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [15:0] w;
    int        r;
    inst       = 16'h0000;
    inst_valid = 1'b0;
    dbg_addr   = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst_inst_ready", 16'(inst_ready), 16'd1);
    chk("rst_bm_e", 16'(bm_e), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    chk("rst_bm_op", 16'(bm_op), 16'd0);
    chk("rst_bm_byte", 16'(bm_byte), 16'd0);
    chk("rst_bm_dst_in", bm_dst_in, 16'h0000);
    rst = 1'b0;
    sweep();

    issue(16'h62D1, 1'b0);
    peek("plan_r1", 3'd1, 16'h005A);

    issue(16'h69A2, 1'b0);
    issue(16'h7892, 1'b0);
    issue(16'h7D5A, 1'b0);
    peek("plan_r2", 3'd2, 16'hAB34);

    issue(16'h7403, 1'b0);
    issue(16'h6BFB, 1'b0);
    peek("plan_r3", 3'd3, 16'h007F);

    issue(16'h69A4, 1'b0);
    issue(16'h7894, 1'b0);
    issue(16'h4D84, 1'b0);
    peek("plan_r4", 3'd4, 16'h3412);
    sweep();

    issue(16'h0000, 1'b0);
    sweep();

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      w = {3'b011, 2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom)};
      else if (r < 7) w = {13'h09B0, 3'($urandom)};
      else            w = 16'($urandom);
      issue(w, 1'($urandom));
      if ($urandom_range(0, 3) == 0) sweep();
    end
    sweep();

    // Reset during EXEC of MOVL R5,#0x11 must abort without writeback.
    @(negedge clk);
    inst       = 16'h608D;
    inst_valid = 1'b1;
    begin
      exp_t e;
      e.ill = 1'b0;
      e.op  = 3'd0;
      e.b   = 8'h11;
      e.din = model[5];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_bme_before", 16'(bm_e), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_bme_dropped", 16'(bm_e), 16'd0);
    chk("abort_no_done", 16'(done), 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    chk("abort_ready", 16'(inst_ready), 16'd1);
    peek("plan_r5", 3'd5, 16'h0000);
    sweep();
    repeat (5) @(negedge clk);

    chk("done_count", 16'(done_cnt), 16'(exp_done_cnt));
    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_op_sequencer.md
# byte_op_sequencer

Issue and writeback stage wrapped around the byte-manipulation unit. It accepts 16-bit instruction words over a valid/ready handshake and decodes MOVL, MOVLZ, MOVLS, MOVH and SWPB. For each legal instruction it reads the destination register from an internal 8×16 register bank and drives the byte-manipulation unit with op/byte/dst_in and its E strobe. It then captures dst_out and writes it back to the destination register. It sits between instruction fetch and the byte-manipulation unit.

## Interface
Parameters:
- NREGS, 8, number of general registers (R0–R7); fixed at 8, dst field is 3 bits.
- RST_VAL, 16'h0000, reset value of every register.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst  in  16  instruction word.
- inst_valid  in  1  inst is valid this cycle.
- inst_ready  out  1  sequencer can accept an instruction (high only in IDLE).
- bm_op  out  3  op to byte-manipulation unit (0 MOVL, 1 MOVLZ, 2 MOVLS, 3 MOVH, 4 SWPB).
- bm_byte  out  8  byte operand.
- bm_dst_in  out  16  current destination register value.
- bm_e  out  1  E strobe, one-cycle registered pulse.
- bm_dst_out  in  16  result from byte-manipulation unit.
- done  out  1  one-cycle pulse in the writeback cycle.
- illegal  out  1  one-cycle pulse when an accepted word decodes to none of the five ops.
- dbg_addr  in  3  debug register select.
- dbg_data  out  16  combinational read of register dbg_addr.

## Operation
- Decode:
  - inst[15:13]=3'b011 selects the move group. inst[12:11] gives op 0–3, inst[10:3] gives byte, inst[2:0] gives dst.
  - inst[15:3]=13'h09B0 (word 0x4D80|dst) selects SWPB with op 4, byte = 8'h00, dst = inst[2:0].
  - Any other word is illegal.
- FSM states IDLE, READ, EXEC, WAIT, WB:
  - IDLE: inst_ready=1. On inst_valid, latch op, byte and dst.
    - Legal word: go to READ.
    - Illegal word: pulse illegal next cycle, stay in IDLE. That cycle inst_ready=0, so the next accept is 2 cycles after the illegal one.
  - READ: latch regs[dst] into bm_dst_in. Go to EXEC.
  - EXEC: bm_e=1 for exactly this cycle. bm_op, bm_byte and bm_dst_in are stable from READ through WAIT. Go to WAIT.
  - WAIT: bm_dst_out settles. Go to WB.
  - WB: regs[dst] <= bm_dst_out at the end of the cycle, done=1. Go to IDLE.
- The sequencer writes only the destination register, and only in WB. Illegal words never write.
- bm_op, bm_byte and bm_dst_in hold their last values while IDLE.

## Timing
- Accept at cycle N (inst_valid & inst_ready). READ at N+1, bm_e high at N+2, WAIT at N+3, done high and write at N+4. Next accept is possible at N+5. Throughput is one instruction per 5 cycles.
- Reset values: state IDLE, inst_ready=1, bm_e=0, done=0, illegal=0, bm_op=0, bm_byte=0, bm_dst_in=0, all registers RST_VAL. dbg_data follows register contents.
- Reset asserted mid-operation aborts immediately: no writeback, no done, and bm_e is forced low asynchronously.
- inst_valid while not in IDLE is ignored; the word is not latched. Upstream must hold it.
- dbg_addr equal to dst during WB returns the old value that cycle and the new value from the next cycle.
- Back-to-back instructions on the same register see the prior result, because READ follows the previous WB.

## Structure
- Shared package byte_op_pkg holds:
  - op constants OP_MOVL..OP_SWPB (3-bit);
  - the move-group prefix 3'b011;
  - the SWPB prefix 13'h09B0;
  - the FSM state encoding.
- One sub-module, reg_bank8x16:
  - one write port on clk;
  - one synchronous-latched read port for dst;
  - one combinational debug read port;
  - asynchronous reset to RST_VAL.
- FSM and decode live in the top.

## Test plan
- After reset, MOVL R1,#0x5A (0x62D1) → bm_op=0, bm_byte=0x5A, bm_dst_in=0x0000. bm_e at N+2, done at N+4, R1=0x005A.
- R2=0x1234, then MOVH R2,#0xAB (0x7D5A) → bm_op=3, bm_dst_in=0x1234, R2=0xAB34.
- MOVLS R3,#0x80 (0x7403) then MOVLZ R3,#0x7F (0x6BFB) → second issue sees bm_dst_in=0xFF80 and writes R3=0x007F.
- R4=0x1234, then SWPB R4 (0x4D84) → bm_op=4, bm_dst_in=0x1234, R4=0x3412. No other register changes.
- 0x0000 presented → illegal pulse one cycle after accept, no bm_e, no done, all registers unchanged, inst_ready back at 2 cycles.
- Assert rst in the EXEC cycle of MOVL R5,#0x11 → bm_e drops immediately, no done, R5=0x0000, inst_ready=1 after release.
